// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the write-port arbiter in front of Async_fifo.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned PICK_W   = 3;
    localparam int unsigned CAND_W   = PICK_W + 1;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // Index width for n requesters; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req[0..n-1] searching ptr, ptr+1, ... with explicit wrap at n.
    function automatic pick_t rr_find_first(input logic [MAX_NREQ-1:0] req,
                                            input logic [PICK_W-1:0]   ptr,
                                            input logic [CAND_W-1:0]   n);
        pick_t             res;
        logic [CAND_W-1:0] cand;
        res = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            cand = {1'b0, ptr} + CAND_W'(k);
            if (cand >= n) begin
                cand = cand - n;
            end
            if ((CAND_W'(k) < n) && !res.found && req[cand[PICK_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[PICK_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after ptr.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned OW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   ptr,
    output logic [OW-1:0]   idx_c,
    output logic            any_c
);

    pick_t pick;

    always_comb begin
        pick  = rr_find_first(MAX_NREQ'(req), PICK_W'(ptr), CAND_W'(NREQ));
        idx_c = OW'(pick.idx);
        any_c = pick.found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the Async_fifo write port among NREQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned WIDTH     = 4,
    parameter  int unsigned NREQ      = 4,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned OW        = idx_w(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wreset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_gnt,
    input  logic                  fifo_full,
    output logic                  wen,
    output logic [WIDTH-1:0]      wdata,
    output logic [OW-1:0]         owner,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    state_t          state, next_state;
    logic [OW-1:0]   rr_ptr, next_rr;
    logic [OW-1:0]   next_owner;
    logic [CW-1:0]   burst_cnt, next_cnt;
    logic [OW-1:0]   pick_idx;
    logic            pick_any;
    logic            release_c;

    rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx_c (pick_idx),
        .any_c (pick_any)
    );

    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= next_state;
            rr_ptr    <= next_rr;
            owner     <= next_owner;
            burst_cnt <= next_cnt;
        end
    end

    // Write strobes follow the owner's valid in the same cycle; full always wins.
    always_comb begin
        next_state = state;
        next_rr    = rr_ptr;
        next_owner = owner;
        next_cnt   = burst_cnt;
        wen        = 1'b0;
        req_gnt    = '0;
        wdata      = '0;
        release_c  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    next_owner = pick_idx;
                    next_cnt   = '0;
                    next_state = BURST;
                end
            end
            BURST: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (owner == OW'(i)) begin
                        wdata = req_data[i*WIDTH +: WIDTH];
                    end
                end
                wen = req_valid[owner] & ~fifo_full;
                for (int i = 0; i < NREQ; i++) begin
                    req_gnt[i] = wen & (owner == OW'(i));
                end
                if (wen) begin
                    if (burst_cnt == CW'(MAX_BURST - 1)) begin
                        release_c = 1'b1;
                    end else begin
                        next_cnt = burst_cnt + CW'(1);
                    end
                end else if (!fifo_full) begin
                    release_c = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (release_c) begin
            next_state = IDLE;
            next_cnt   = '0;
            next_rr    = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
        end
    end

    assign busy = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_fifo_wr_arbiter;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned OW        = 2;
    localparam int unsigned DEPTH     = 8;

    logic                  wclk = 1'b0;
    logic                  wreset_n = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_gnt;
    logic                  fifo_full;
    logic                  wen;
    logic [WIDTH-1:0]      wdata;
    logic [OW-1:0]         owner;
    logic                  busy;

    fifo_wr_arbiter #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk      (wclk),
        .wreset_n  (wreset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_gnt   (req_gnt),
        .fifo_full (fifo_full),
        .wen       (wen),
        .wdata     (wdata),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    // Transaction-level model: who owns the port, how many words this grant, where the search starts.
    bit  m_busy;
    int  m_owner, m_words, m_ptr;

    logic [WIDTH-1:0] wq [NREQ][$];
    bit   drop [NREQ];
    bit   rand_en, fifo_mode, full_forced;
    int   fifo_cnt;

    logic [31:0] wen_hist, own_seq, data_seq;
    int          ncyc, ngnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            drop[i] = rand_en && ($urandom_range(0, 15) == 0);
            req_valid[i] = (wq[i].size() > 0) && !drop[i];
            req_data[i*WIDTH +: WIDTH] = (wq[i].size() > 0) ? wq[i][0] : '0;
        end
        fifo_full = fifo_mode ? (fifo_cnt >= DEPTH) : full_forced;
    endtask

    task automatic clear_hist();
        wen_hist = '0; own_seq = '0; data_seq = '0; ncyc = 0; ngnt = 0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NREQ; i++) wq[i].delete();
    endtask

    // Compare mid-cycle, advance the model, then move to just after the next rising edge.
    task automatic step();
        logic             exp_wen;
        logic [NREQ-1:0]  exp_gnt;
        logic [WIDTH-1:0] exp_wdata;
        bit               rel;
        #3;
        exp_wen = 1'b0; exp_gnt = '0; exp_wdata = '0; rel = 0;
        if (m_busy) begin
            exp_wdata = req_data[m_owner*WIDTH +: WIDTH];
            exp_wen   = req_valid[m_owner] && !fifo_full;
            exp_gnt   = exp_wen ? (NREQ'(1) << m_owner) : '0;
            chk("owner", 32'(owner), 32'(m_owner));
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("wen", 32'(wen), 32'(exp_wen));
        chk("req_gnt", 32'(req_gnt), 32'(exp_gnt));
        chk("wdata", 32'(wdata), 32'(exp_wdata));
        if (ncyc < 32) wen_hist[ncyc] = wen;
        ncyc++;
        if (wen) begin
            own_seq  = {own_seq[29:0], owner};
            data_seq = {data_seq[27:0], wdata};
            ngnt++;
        end
        if (!m_busy) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
            end
            if (|req_valid) begin
                m_busy  = 1;
                m_words = 0;
            end
        end else if (exp_wen) begin
            m_words++;
            if (m_words == MAX_BURST) rel = 1;
        end else if (!fifo_full) begin
            rel = 1;
        end
        if (rel) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) void'(wq[i].pop_front());
            if (rand_en && wq[i].size() < 3 && $urandom_range(0, 3) == 0)
                wq[i].push_back(WIDTH'($urandom));
        end
        if (fifo_mode) begin
            if (exp_wen) fifo_cnt++;
            if (fifo_cnt > 0 && $urandom_range(0, 2) == 0) fifo_cnt--;
        end else if (rand_en) begin
            full_forced = ($urandom_range(0, 4) == 0);
        end
        @(posedge wclk);
        #1;
        drive();
    endtask

    // Asserted mid-cycle: outputs must fall at once, without waiting for a clock edge.
    task automatic do_reset();
        wreset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_gnt", 32'(req_gnt), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        m_busy = 0; m_owner = 0; m_words = 0; m_ptr = 0;
        @(posedge wclk);
        #1;
        wreset_n = 1'b1;
        drive();
    endtask

    initial begin
        rand_en = 0; fifo_mode = 0; full_forced = 0; fifo_cnt = 0;
        req_valid = '0; req_data = '0; fifo_full = 1'b0;
        clear_queues();
        clear_hist();
        #2;
        do_reset();

        // Single requester, five words: arb, four writes, re-arb, one write.
        clear_hist();
        wq[0] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        drive();
        repeat (7) step();
        chk("single_wen_hist", 32'(wen_hist[6:0]), 32'b1011110);
        chk("single_data", data_seq, 32'h000ABCDE);

        // All four requesting: owners 0,1,2,3 each for four words, one arb cycle apart.
        do_reset();
        clear_queues();
        clear_hist();
        for (int i = 0; i < NREQ; i++)
            for (int w = 0; w < 5; w++) wq[i].push_back(WIDTH'($urandom));
        drive();
        for (int c = 0; c < 40 && ngnt < 16; c++) step();
        chk("rr_cycles", 32'(ncyc), 32'd20);
        chk("rr_owner_seq", own_seq, 32'h0055AAFF);

        // Full stall after two words of requester 1.
        do_reset();
        clear_queues();
        clear_hist();
        for (int w = 0; w < 4; w++) wq[1].push_back(WIDTH'(w + 3));
        drive();
        repeat (3) step();
        full_forced = 1; drive();
        repeat (6) step();
        chk("stall_owner", 32'(owner), 32'd1);
        chk("stall_busy", 32'(busy), 32'd1);
        full_forced = 0; drive();
        repeat (3) step();
        chk("stall_wen_hist", 32'(wen_hist[11:0]), 32'h606);
        chk("stall_data", data_seq, 32'h00003456);

        // Early end by requester 3 wraps the pointer so requester 0 goes next.
        do_reset();
        clear_queues();
        clear_hist();
        wq[2].push_back(4'h1);
        drive();
        repeat (4) step();
        wq[3].push_back(4'h7);
        wq[0].push_back(4'h9);
        drive();
        repeat (6) step();
        chk("early_owner_seq", 32'(own_seq[5:0]), 32'b101100);
        chk("early_data", 32'(data_seq[11:0]), 32'h179);

        // Reset while requester 2 is mid-burst; next search restarts at 0.
        do_reset();
        clear_queues();
        clear_hist();
        for (int w = 0; w < 8; w++) wq[2].push_back(WIDTH'(w));
        drive();
        repeat (3) step();
        chk("mid_owner_before", 32'(owner), 32'd2);
        do_reset();
        wq[1].push_back(4'h5);
        drive();
        step();
        chk("mid_owner_after", 32'(owner), 32'd1);
        chk("mid_busy_after", 32'(busy), 32'd1);
        repeat (3) step();

        // Random traffic with random full, then against a depth-8 fifo model.
        do_reset();
        clear_queues();
        clear_hist();
        rand_en = 1;
        drive();
        repeat (2000) step();
        fifo_mode = 1; full_forced = 0; fifo_cnt = 0;
        drive();
        repeat (2000) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
